bp_be_int_box_pipe: RTL and testbench

BP_BE_INT_BOX_PIPE -- requirements
Module: bp_be_int_box_pipe

---
 rtl/bp_be_int_box_pipe.sv | 117 +++++++++++
 tb/tb_bp_be_int_box_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bp_be_int_box_pipe.sv
// rtl/bp_be_int_box_pipe.sv - boxes a raw integer result to its tag width and buffers it in a 2-entry FIFO
// Optional feature macro: BP_BE_INT_BOX_UNSIGNED_EN (honour unsigned_i with zero extension).
package bp_be_int_box_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef enum logic [1:0] {
    e_int_byte  = 2'd0,
    e_int_hword = 2'd1,
    e_int_word  = 2'd2,
    e_int_dword = 2'd3
  } bp_be_int_tag_e;

  typedef struct packed {
    bp_be_int_tag_e tag;
    logic [63:0]    val;
  } bp_be_int_reg_s;

endpackage

module bp_be_int_box_pipe
  import bp_be_int_box_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  localparam int dword_width_gp   = (bp_params_p == e_bp_default_cfg) ? 64 : 64,
  localparam int int_rec_width_gp = (bp_params_p == e_bp_default_cfg) ? 66 : 66,
  localparam int dpath_width_gp   = $bits(bp_be_int_reg_s)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic                        v_i,
  output logic                        ready_and_o,
  input  logic [int_rec_width_gp-1:0] val_i,
  input  logic [1:0]                  tag_i,
  input  logic                        unsigned_i,

  output logic                        v_o,
  input  logic                        ready_and_i,
  output logic [dpath_width_gp-1:0]   reg_o,
  output logic [1:0]                  count_o
);

  logic                      sext;
  logic [dword_width_gp-1:0] boxed_val;
  bp_be_int_reg_s            new_entry;
  logic                      unused_inputs;

`ifdef BP_BE_INT_BOX_UNSIGNED_EN
  assign sext          = ~unsigned_i;
  assign unused_inputs = ^val_i[int_rec_width_gp-1:dword_width_gp];
`else
  assign sext          = 1'b1;
  assign unused_inputs = ^{unsigned_i, val_i[int_rec_width_gp-1:dword_width_gp]};
`endif

  // Boxing happens ahead of the buffer so entries are already final registers.
  always_comb begin
    boxed_val = val_i[dword_width_gp-1:0];
    unique case (tag_i)
      e_int_byte:  boxed_val = {{56{sext & val_i[7]}},  val_i[7:0]};
      e_int_hword: boxed_val = {{48{sext & val_i[15]}}, val_i[15:0]};
      e_int_word:  boxed_val = {{32{sext & val_i[31]}}, val_i[31:0]};
      e_int_dword: boxed_val = val_i[dword_width_gp-1:0];
      default:     boxed_val = val_i[dword_width_gp-1:0];
    endcase
  end

  assign new_entry.tag = bp_be_int_tag_e'(tag_i);
  assign new_entry.val = boxed_val;

  logic           wptr_q, wptr_d;
  logic           rptr_q, rptr_d;
  logic [1:0]     count_q, count_d;
  bp_be_int_reg_s mem_q [2];
  logic           push, pop;

  assign ready_and_o = (count_q != 2'd2);
  assign v_o         = (count_q != 2'd0);
  assign count_o     = count_q;
  assign push        = v_i & ready_and_o;
  assign pop         = v_o & ready_and_i;
  assign reg_o       = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = ~wptr_q;
    if (pop)  rptr_d = ~rptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately unreset; v_o masks whatever it holds.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= new_entry;
  end

endmodule

// File: tb/tb_bp_be_int_box_pipe.sv
// tb/tb_bp_be_int_box_pipe.sv - scoreboard bench for bp_be_int_box_pipe
module tb_bp_be_int_box_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v_i = 1'b0;
  logic        ready_and_o;
  logic [65:0] val_i = '0;
  logic [1:0]  tag_i = '0;
  logic        unsigned_i = 1'b0;
  logic        v_o;
  logic        ready_and_i = 1'b0;
  logic [65:0] reg_o;
  logic [1:0]  count_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [65:0] exp_q [$];

  always #5 clk = ~clk;

  bp_be_int_box_pipe dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .v_i         (v_i),
    .ready_and_o (ready_and_o),
    .val_i       (val_i),
    .tag_i       (tag_i),
    .unsigned_i  (unsigned_i),
    .v_o         (v_o),
    .ready_and_i (ready_and_i),
    .reg_o       (reg_o),
    .count_o     (count_o)
  );

  function automatic logic [65:0] box_model(logic [63:0] v, logic [1:0] t, logic u);
    int          nbits;
    logic [63:0] mask;
    logic [63:0] r;
    logic        zext;
    nbits = 8 << t;
    if (nbits == 64) return {t, v};
    mask = (64'd1 << nbits) - 64'd1;
    r    = v & mask;
`ifdef BP_BE_INT_BOX_UNSIGNED_EN
    zext = u;
`else
    zext = 1'b0;
`endif
    if (!zext && v[nbits-1]) r = r | ~mask;
    return {t, r};
  endfunction

  task automatic check(string name, logic [65:0] act, logic [65:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: state checks against queue depth, pop/compare outputs, then record acceptances.
  always @(negedge clk) begin
    if (reset_n) begin
      check("count_vs_model", {64'd0, count_o}, 66'(exp_q.size()));
      check("v_o_vs_model", {65'd0, v_o}, {65'd0, exp_q.size() != 0});
      check("ready_vs_model", {65'd0, ready_and_o}, {65'd0, exp_q.size() != 2});
      if (v_o && ready_and_i) begin
        if (exp_q.size() == 0) check("unexpected_output", reg_o, 66'h0 ^ ~reg_o);
        else check("reg_o", reg_o, exp_q.pop_front());
      end
      if (v_i && ready_and_o) exp_q.push_back(box_model(val_i[63:0], tag_i, unsigned_i));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [63:0] val, logic [1:0] tag, logic u, logic rdy);
    v_i = v;
    val_i = {2'($urandom), val};
    tag_i = tag;
    unsigned_i = u;
    ready_and_i = rdy;
    step();
  endtask

  task automatic drain();
    int budget;
    v_i = 1'b0;
    ready_and_i = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      step();
      budget++;
    end
    check("drain_empty", 66'(exp_q.size()), 66'd0);
  endtask

  initial begin
    #2;
    check("reset_count", {64'd0, count_o}, 66'd0);
    check("reset_v_o", {65'd0, v_o}, 66'd0);
    check("reset_ready", {65'd0, ready_and_o}, 66'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Directed boxing cases, first push right after reset release.
    drive(1'b1, 64'h00000000_000000F0, 2'd0, 1'b0, 1'b1);
    v_i = 1'b0;
    #4;
    check("byte_f0_v_o", {65'd0, v_o}, 66'd1);
    check("byte_f0_reg", reg_o, {2'd0, 64'hFFFFFFFF_FFFFFFF0});
    step();
    drive(1'b1, 64'h12345678_80000000, 2'd2, 1'b1, 1'b1);
    drive(1'b1, 64'h00000000_00007FFF, 2'd1, 1'b0, 1'b1);
    drive(1'b1, 64'h00000000_00008000, 2'd1, 1'b0, 1'b1);
    drive(1'b1, 64'hFFFFFFFF_FFFFFF80, 2'd0, 1'b1, 1'b1);
    drive(1'b1, 64'h80000000_0000FFFF, 2'd3, 1'b1, 1'b1);
    drain();

    // Backpressure: three attempts with ready low, only two fit.
    for (int i = 0; i < 3; i++) drive(1'b1, 64'(i + 64'hA0), 2'd3, 1'b0, 1'b0);
    check("full_count", {64'd0, count_o}, 66'd2);
    check("full_ready", {65'd0, ready_and_o}, 66'd0);
    v_i = 1'b0;
    ready_and_i = 1'b1;
    #1 check("pop_cycle_ready", {65'd0, ready_and_o}, 66'd0);
    step();
    ready_and_i = 1'b0;
    check("after_pop_ready", {65'd0, ready_and_o}, 66'd1);
    check("after_pop_count", {64'd0, count_o}, 66'd1);
    drain();

    // Streaming: ten back-to-back dwords.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h1000 + 64'(i), 2'd3, 1'b0, 1'b1);
      check("stream_count", {64'd0, count_o}, 66'd1);
    end
    drain();

    // Async reset mid-operation with the buffer full.
    drive(1'b1, 64'h55, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 64'h66, 2'd3, 1'b0, 1'b0);
    v_i = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_v_o", {65'd0, v_o}, 66'd0);
    check("async_rst_count", {64'd0, count_o}, 66'd0);
    exp_q.delete();
    step();
    reset_n = 1'b1;
    ready_and_i = 1'b1;
    #2 check("post_rst_no_stale", {65'd0, v_o}, 66'd0);
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), {$urandom, $urandom}, 2'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
